// File: rtl/fifo_uart_pkg.sv
// Shared types and frame constants for the FIFO-to-UART drain path (TX now, RX later).
package fifo_uart_pkg;

    localparam int DEF_DATA_W = 10;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } drain_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops words from the FIFO and serialises them onto tx, LSB first.
// Build option: FIFO_UART_DRAIN_PARITY_EN adds an even-parity bit after the data bits.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

    // state  | meaning
    // IDLE   | wait for enable and data     POP   | one-cycle pop pulse
    // WAIT   | pop low, capture fifo_data   START/DATA/PARITY/STOP | frame bits
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    drain_state_e      state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  words_d;
    logic              tx_d;
    logic              tick;
    logic              baud_clear;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    logic              parity_q;
`endif

    // Timer held at zero outside bit states so each START gets a full period.
    assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == WAIT);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        words_d = words_sent;
        case (state_q)
            IDLE: if (enable && !fifo_empty) state_d = POP;
            POP:  state_d = WAIT;
            WAIT: begin
                shift_d = fifo_data;
                bit_d   = '0;
                state_d = START;
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef FIFO_UART_DRAIN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: begin
                if (tick) begin
                    words_d = words_sent + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so the line level is chosen for the upcoming state.
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:  tx_d = START_BIT;
            DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_DRAIN_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            STOP:   tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            words_sent <= '0;
            fifo_pop   <= 1'b0;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            words_sent <= words_d;
            fifo_pop   <= (state_d == POP);
            tx         <= tx_d;
            busy       <= (state_d != IDLE);
        end
    end

`ifdef FIFO_UART_DRAIN_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (state_q == WAIT) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: FIFO model on the read port, frames checked against an ideal bit stream.
module tb_fifo_uart_drain;

    localparam int DW = 10;
    localparam int B  = 4;
    localparam int CW = 16;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FB = DW + 2 + PAR;
    localparam int FL = FB * B;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic [CW-1:0] words_sent;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_words = '0;

    logic [DW-1:0] mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pop_total = 0;
    int            consec_pops = 0;
    logic          prev_pop = 1'b0;

    fifo_uart_drain #(
        .DATA_W(DW),
        .CLKS_PER_BIT(B),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pop && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_pop) pop_total <= pop_total + 1;
        if (fifo_pop && prev_pop) consec_pops <= consec_pops + 1;
        prev_pop <= fifo_pop;
    end

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp_stream(input logic [DW-1:0] w);
        logic [FB-1:0] fb;
        logic [63:0]   s;
        fb = '0;
        fb[0] = 1'b0;
        for (int j = 0; j < DW; j++) fb[1+j] = w[j];
        if (PAR == 1) fb[DW+1] = ^w;
        fb[FB-1] = 1'b1;
        s = '0;
        for (int c = 0; c < FL; c++) s[c] = fb[c/B];
        return s;
    endfunction

    // Waits for a pop, then records the pop width, the WAIT-cycle line level and the frame.
    task automatic capture_frame(input int drop_at, output logic [63:0] stream, output int pop_len,
                                 output int n, output logic wait_tx, output logic busy_all,
                                 output logic gap_high, output logic timeout);
        stream   = '0;
        pop_len  = 0;
        n        = 0;
        busy_all = 1'b1;
        gap_high = 1'b1;
        timeout  = 1'b0;
        while (fifo_pop !== 1'b1 && n < 2000) begin
            if (tx !== 1'b1) gap_high = 1'b0;
            step(1);
            n++;
        end
        if (n >= 2000) begin
            timeout = 1'b1;
            wait_tx = 1'b0;
            return;
        end
        while (fifo_pop === 1'b1 && pop_len < 5) begin
            if (tx !== 1'b1) gap_high = 1'b0;
            pop_len++;
            step(1);
        end
        wait_tx = tx;
        step(1);
        for (int c = 0; c < FL; c++) begin
            if (c == drop_at) enable = 1'b0;
            stream[c] = tx;
            if (busy !== 1'b1) busy_all = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if ({fifo_pop, tx, busy, words_sent} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d pop/tx/busy/words got=%b/%b/%b/%0d want 0/1/0/0",
                         i, fifo_pop, tx, busy, words_sent);
            end
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (fifo_pop !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_pop got=%b want=1", fifo_pop);
        end
    endtask

    task automatic test_single_word();
        logic [63:0] s;
        int pl, n;
        logic wt, ba, gh, to;
        capture_frame(-1, s, pl, n, wt, ba, gh, to);
        exp_words++;
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got=%b want=0", to); end
        checks++;
        if (pl !== 1) begin errors++; $display("FAIL single_pop_len got=%0d want=1", pl); end
        checks++;
        if (wt !== 1'b1) begin errors++; $display("FAIL single_wait_tx got=%b want=1", wt); end
        checks++;
        if (s !== exp_stream(10'h2A5)) begin
            errors++;
            $display("FAIL single_stream got=%h want=%h", s, exp_stream(10'h2A5));
        end
        checks++;
        if ({ba, busy} !== 2'b10) begin
            errors++;
            $display("FAIL single_busy_window during/after got=%b/%b want 1/0", ba, busy);
        end
        checks++;
        if ({words_sent, tx} !== {exp_words, 1'b1}) begin
            errors++;
            $display("FAIL single_words words/tx got=%0d/%b want %0d/1", words_sent, tx, exp_words);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [3];
        logic [63:0] s;
        int pl, n, pops0;
        logic wt, ba, gh, to;
        words[0] = 10'h001;
        words[1] = 10'h3FF;
        words[2] = 10'h155;
        pops0 = pop_total;
        for (int k = 0; k < 3; k++) push(words[k]);
        for (int k = 0; k < 3; k++) begin
            capture_frame(-1, s, pl, n, wt, ba, gh, to);
            exp_words++;
            checks++;
            if (s !== exp_stream(words[k])) begin
                errors++;
                $display("FAIL b2b_stream k=%0d got=%h want=%h", k, s, exp_stream(words[k]));
            end
            checks++;
            if ({pl, wt} !== {32'd1, 1'b1}) begin
                errors++;
                $display("FAIL b2b_pop k=%0d pop_len/wait_tx got=%0d/%b want 1/1", k, pl, wt);
            end
            checks++;
            if ({n, gh} !== {32'd1, 1'b1}) begin
                errors++;
                $display("FAIL b2b_gap k=%0d idle_cycles/tx_high got=%0d/%b want 1/1", k, n, gh);
            end
        end
        step(20);
        checks++;
        if (pop_total - pops0 !== 3) begin
            errors++;
            $display("FAIL b2b_pop_count got=%0d want=3", pop_total - pops0);
        end
        checks++;
        if ({words_sent, busy, tx} !== {exp_words, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_end words/busy/tx got=%0d/%b/%b want %0d/0/1", words_sent, busy, tx, exp_words);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        logic [63:0] s;
        int pl, n;
        logic wt, ba, gh, to;
        for (int k = 0; k < 4; k++) begin
            w = DW'($urandom_range(0, 1023));
            step($urandom_range(0, 5));
            push(w);
            capture_frame(-1, s, pl, n, wt, ba, gh, to);
            exp_words++;
            checks++;
            if (s !== exp_stream(w)) begin
                errors++;
                $display("FAIL rand_stream w=%h got=%h want=%h", w, s, exp_stream(w));
            end
            checks++;
            if ({n, pl, busy, words_sent} !== {32'd1, 32'd1, 1'b0, exp_words}) begin
                errors++;
                $display("FAIL rand_ctl w=%h n/pop_len/busy/words got=%0d/%0d/%b/%0d want 1/1/0/%0d",
                         w, n, pl, busy, words_sent, exp_words);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [63:0] s;
        int pl, n, pops0;
        logic wt, ba, gh, to;
        push(10'h2C3);
        push(10'h0F0);
        capture_frame(6 * B + 1, s, pl, n, wt, ba, gh, to);
        exp_words++;
        checks++;
        if (s !== exp_stream(10'h2C3)) begin
            errors++;
            $display("FAIL endrop_stream got=%h want=%h", s, exp_stream(10'h2C3));
        end
        pops0 = pop_total;
        step(30);
        checks++;
        if ({pop_total - pops0, busy, words_sent} !== {32'd0, 1'b0, exp_words}) begin
            errors++;
            $display("FAIL endrop_hold pops/busy/words got=%0d/%b/%0d want 0/0/%0d",
                     pop_total - pops0, busy, words_sent, exp_words);
        end
        enable = 1'b1;
        capture_frame(-1, s, pl, n, wt, ba, gh, to);
        exp_words++;
        checks++;
        if ({s, n} !== {exp_stream(10'h0F0), 32'd1}) begin
            errors++;
            $display("FAIL endrop_resume stream/n got=%h/%0d want=%h/1", s, n, exp_stream(10'h0F0));
        end
    endtask

    task automatic test_reset_mid();
        int n, pops0;
        n = 0;
        push(10'h0A8);
        while (fifo_pop !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rstmid_timeout got=%0d want<200", n); end
        step(2 + 4 * B + 1);
        checks++;
        if ({busy, tx, words_sent} !== {1'b1, 1'b1, exp_words}) begin
            errors++;
            $display("FAIL rstmid_pre busy/tx(bit3)/words got=%b/%b/%0d want 1/1/%0d",
                     busy, tx, words_sent, exp_words);
        end
        reset = 1'b1;
        step(1);
        exp_words = '0;
        checks++;
        if ({tx, busy, fifo_pop, words_sent} !== {1'b1, 1'b0, 1'b0, exp_words}) begin
            errors++;
            $display("FAIL rstmid_post tx/busy/pop/words got=%b/%b/%b/%0d want 1/0/0/0",
                     tx, busy, fifo_pop, words_sent);
        end
        reset = 1'b0;
        pops0 = pop_total;
        step(20);
        checks++;
        if ({pop_total - pops0, busy, tx} !== {32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_idle pops/busy/tx got=%0d/%b/%b want 0/0/1", pop_total - pops0, busy, tx);
        end
    endtask

    task automatic test_parity();
        logic [63:0] s;
        int pl, n;
        logic wt, ba, gh, to;
        push(10'h007);
        capture_frame(-1, s, pl, n, wt, ba, gh, to);
        exp_words++;
        checks++;
        if (s !== exp_stream(10'h007)) begin
            errors++;
            $display("FAIL parity_stream got=%h want=%h", s, exp_stream(10'h007));
        end
        checks++;
        if ({ba, busy, words_sent} !== {1'b1, 1'b0, exp_words}) begin
            errors++;
            $display("FAIL parity_len busy_during/after/words got=%b/%b/%0d want 1/0/%0d",
                     ba, busy, words_sent, exp_words);
        end
`ifdef FIFO_UART_DRAIN_PARITY_EN
        checks++;
        if (s[(DW+1)*B +: B] !== 4'b1111) begin
            errors++;
            $display("FAIL parity_bit got=%b want=1111", s[(DW+1)*B +: B]);
        end
`endif
    endtask

    initial begin
        push(10'h2A5);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_reset_mid();
        test_parity();
        checks++;
        if (consec_pops !== 0) begin
            errors++;
            $display("FAIL pop_consecutive got=%0d want=0", consec_pops);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
